cnt_prog: RTL and testbench
===========================

Name: cnt_prog

Overview:
- Programmable, parametrised modulo counter; successor to the basic single-mode wrap counter used for display/timebase generation.
- Adds up/down direction, free-run vs one-shot mode, synchronous load, clear, start control, built-in ce prescaler, done pulse and cascadable carry.
- Sits between the board timebase and the display/scan/timer logic. One instance per timer or scan channel. Instances cascade via co into the next instance's ce.

Parameters:
- WIDTH, 16, counter width in bits (q, max, ld_val).
- RST_VLU, 0, value of q after rst (must be <= 2^WIDTH-1).
- PRESC_W, 8, prescaler divider width; 0 is not allowed (minimum 1).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  count enable (or cascade input from upstream co).
- div  in  PRESC_W  prescaler: internal tick every (div+1) ce-qualified cycles; div=0 means tick on every ce.
- max  in  WIDTH  terminal count (modulus-1).
- dir  in  1  0 = up, 1 = down.
- mode  in  1  0 = FREE (wrap), 1 = ONESHOT (stop at terminal).
- start  in  1  begin/resume counting.
- clr  in  1  synchronous clear.
- ld  in  1  synchronous load strobe.
- ld_val  in  WIDTH  load value.
- q  out  WIDTH  counter value (registered).
- co  out  1  carry/borrow: terminal reached on a tick (combinational).
- busy  out  1  high while in RUN (registered state decode).
- done  out  1  one-cycle pulse on ONESHOT completion (registered).

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high; no asynchronous reset anywhere.
- Reset: q=RST_VLU, state=IDLE, prescaler=0, done=0; busy=0; co=0.
- Priority per cycle: rst > clr > ld > start > tick count.
- tick = ce & (presc==div) & (state==RUN). Prescaler increments on ce in RUN and wraps to 0 on tick. It is cleared on rst, clr and start-accept.
- Terminal condition: up = (q >= max); down = (q == 0). The ">=" handles max lowered below q at runtime.
- co = tick & terminal. Zero latency, same cycle as the terminal tick.
- States:
  - IDLE: start -> RUN.
  - RUN: on tick & terminal & mode=ONESHOT -> DONE.
  - DONE: start -> RUN.
  - start while in RUN is ignored (prescaler not cleared).
- Count on tick, when not terminal: q +/- 1.
- Count on tick, when terminal:
  - FREE, up: q <= 0.
  - FREE, down: q <= max.
  - ONESHOT: q holds; done pulses high in the next cycle only.
- Restart from DONE: start does not reload q. Software issues clr or ld first. If q is still terminal, the first tick re-asserts co and returns to DONE.
- clr: q <= 0 if dir=0, else q <= max. State -> IDLE. done is not asserted.
- ld: q <= min(ld_val, max). State and prescaler are unchanged. If ld and a tick occur in the same cycle, the ld wins and the count is lost.
- dir, mode, max and div are sampled every cycle; changes take effect on the next tick.
- max=0: every tick is terminal; q stays 0; co fires on each tick in FREE.
- rst mid-RUN: returns to reset values on the next edge; done is not emitted.
- Width: all arithmetic is modulo 2^WIDTH; q never exceeds max after a wrap.

Decomposition:
- Shared package cnt_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding).
  - constants DIR_UP/DIR_DN and MODE_FREE/MODE_ONESHOT.
- One natural sub-module: cnt_presc (PRESC_W-bit tick divider with ce, div, clear, and tick output), also reusable for standalone timebases.
- Core FSM and datapath stay in cnt_prog.

Test Plan (WIDTH=8, PRESC_W=4):
- FREE up, max=4, div=0, ce=1, start: q 0,1,2,3,4,0,… -> co high exactly on q=4 cycles, period 5; busy=1; done never asserted.
- FREE down, max=9, div=2, ce=1, after clr (q=9): q decrements every 3rd cycle 9..0,9 -> co on tick at q=0; prescaler spacing is 3 cycles.
- ONESHOT up, max=3: start -> q reaches 3 and holds; co one cycle; done pulses the next cycle; busy drops to 0. A start with q=3 re-fires co/done on the first tick. clr then start counts 0..3 again.
- ld priority: in RUN at q=5 with max=10, assert ld=1, ld_val=200 in the same cycle as a tick -> q=10 (clamped), tick discarded. ld_val=7 -> q=7.
- Runtime max change: FREE up at q=8, set max=5 -> next tick wraps q to 0 with co=1.
- Cascade: two instances, lower.co -> upper.ce, both max=9, div=0. After 100 clocks (lower upper) = (0,0), with the upper co pulse on the 100th tick. rst asserted mid-count returns both to RST_VLU, IDLE on the next edge.

Source files
------------

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state encoding and control constants for the programmable counter.
package cnt_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DN       = 1'b1;
   localparam logic MODE_FREE    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/cnt_presc.sv
// cnt_presc: ce-qualified tick divider, one tick every (div+1) enabled ce cycles.
module cnt_presc #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] div,
   output logic         tick
);
   logic [W-1:0] cnt;
   assign tick = en & ce & (cnt == div);
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en && ce) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/cnt_prog.sv
// cnt_prog: programmable up/down modulo counter with free-run/one-shot modes,
// load, clear, prescaled ticks, done pulse and cascadable carry.
module cnt_prog
   import cnt_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int RST_VLU = 0,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic [PRESC_W-1:0] div,
   input  logic [WIDTH-1:0]   max,
   input  logic               dir,
   input  logic               mode,
   input  logic               start,
   input  logic               clr,
   input  logic               ld,
   input  logic [WIDTH-1:0]   ld_val,
   output logic [WIDTH-1:0]   q,
   output logic               co,
   output logic               busy,
   output logic               done
);
   state_t           state;
   logic             tick, term, start_acc;
   logic [WIDTH-1:0] ld_clamp, q_wrap, q_step;
   // ">=" keeps an up-counter terminal when max is lowered below q at runtime
   assign term      = (dir == DIR_DN) ? (q == '0) : (q >= max);
   assign co        = tick & term;
   assign busy      = state == RUN;
   assign start_acc = start & ~clr & ~ld & (state != RUN);
   assign ld_clamp  = (ld_val > max) ? max : ld_val;
   assign q_wrap    = (dir == DIR_DN) ? max : '0;
   assign q_step    = (dir == DIR_DN) ? q - 1'b1 : q + 1'b1;
   cnt_presc #(.W(PRESC_W)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .en   (busy),
      .clr  (clr | start_acc),
      .div  (div),
      .tick (tick)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= WIDTH'(RST_VLU);
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clr) begin
            q     <= q_wrap;
            state <= IDLE;
         end else if (ld) q <= ld_clamp;
         else if (start_acc) state <= RUN;
         else if (tick) begin
            if (!term) q <= q_step;
            else if (mode == MODE_FREE) q <= q_wrap;
            else begin
               state <= DONE;
               done  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_cnt_prog.sv
// tb_cnt_prog: directed test of cnt_prog against a cycle model, plus a two-stage cascade.
module tb_cnt_prog;
   logic       clk = 0;
   logic       rst, ce, dir, mode, start, clr, ld;
   logic [3:0] div;
   logic [7:0] max, ld_val, q;
   logic       co, busy, done;
   logic       c_rst, c_start;
   logic [7:0] c0_q, c1_q;
   logic       c0_co, c1_co, c0_busy, c1_busy, c0_done, c1_done;
   int         n_chk = 0, n_fail = 0;
   int         m_q, m_p;
   bit         m_run, m_done, mon = 0;

   always #5 clk = ~clk;

   cnt_prog #(.WIDTH(8), .RST_VLU(3), .PRESC_W(4)) dut (
      .clk(clk), .rst(rst), .ce(ce), .div(div), .max(max), .dir(dir), .mode(mode),
      .start(start), .clr(clr), .ld(ld), .ld_val(ld_val),
      .q(q), .co(co), .busy(busy), .done(done)
   );
   cnt_prog #(.WIDTH(8), .RST_VLU(0), .PRESC_W(4)) c0 (
      .clk(clk), .rst(c_rst), .ce(1'b1), .div(4'd0), .max(8'd9), .dir(1'b0), .mode(1'b0),
      .start(c_start), .clr(1'b0), .ld(1'b0), .ld_val(8'd0),
      .q(c0_q), .co(c0_co), .busy(c0_busy), .done(c0_done)
   );
   cnt_prog #(.WIDTH(8), .RST_VLU(0), .PRESC_W(4)) c1 (
      .clk(clk), .rst(c_rst), .ce(c0_co), .div(4'd0), .max(8'd9), .dir(1'b0), .mode(1'b0),
      .start(c_start), .clr(1'b0), .ld(1'b0), .ld_val(8'd0),
      .q(c1_q), .co(c1_co), .busy(c1_busy), .done(c1_done)
   );

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: checks outputs mid-cycle, then advances using the inputs held for the coming edge.
   always @(negedge clk) begin
      bit tk, term;
      term = dir ? (m_q == 0) : (m_q >= int'(max));
      tk   = ce && m_run && (m_p == int'(div));
      if (mon) begin
         chk("mdl_q", 32'(q), 32'(m_q));
         chk("mdl_busy", 32'(busy), 32'(m_run));
         chk("mdl_done", 32'(done), 32'(m_done));
         chk("mdl_co", 32'(co), 32'(tk && term));
      end
      if (rst) begin
         m_q = 3; m_run = 0; m_p = 0; m_done = 0; mon = 1;
      end else begin
         m_done = 0;
         if (m_run && ce) m_p = tk ? 0 : (m_p + 1) % 16;
         if (clr) begin
            m_q = dir ? int'(max) : 0; m_run = 0; m_p = 0;
         end else if (ld) m_q = (ld_val > max) ? int'(max) : int'(ld_val);
         else if (start && !m_run) begin
            m_run = 1; m_p = 0;
         end else if (tk) begin
            if (!term) m_q = dir ? m_q - 1 : m_q + 1;
            else if (!mode) m_q = dir ? int'(max) : 0;
            else begin
               m_run = 0; m_done = 1;
            end
         end
      end
   end

   initial begin
      rst = 1; ce = 1; dir = 0; mode = 0; start = 0; clr = 0; ld = 0;
      div = 0; max = 4; ld_val = 0; c_rst = 1; c_start = 0;
      step(); step();
      rst = 0; c_rst = 0;
      step();
      chk("rst_q", 32'(q), 3); chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0); chk("rst_co", 32'(co), 0);
      // FREE up, max=4
      clr = 1; step(); clr = 0;
      chk("up_clr_q", 32'(q), 0);
      start = 1; step(); start = 0;
      chk("up_busy", 32'(busy), 1);
      for (int i = 1; i <= 4; i++) begin
         step(); chk("up_q", 32'(q), 32'(i));
      end
      chk("up_co_at4", 32'(co), 1);
      step(); chk("up_wrap_q", 32'(q), 0); chk("up_co_at0", 32'(co), 0);
      repeat (10) step();
      // FREE down, max=9, div=2
      dir = 1; max = 9; clr = 1; step(); clr = 0;
      chk("dn_clr_q", 32'(q), 9);
      div = 2; start = 1; step(); start = 0;
      repeat (3) step(); chk("dn_q", 32'(q), 8);
      for (int k = 7; k >= 0; k--) begin
         repeat (3) step(); chk("dn_q", 32'(q), 32'(k));
      end
      repeat (2) step(); chk("dn_co_at0", 32'(co), 1);
      step(); chk("dn_wrap_q", 32'(q), 9);
      // ONESHOT up, max=3
      dir = 0; mode = 1; max = 3; div = 0; clr = 1; step(); clr = 0;
      start = 1; step(); start = 0;
      repeat (3) step();
      chk("os_q3", 32'(q), 3); chk("os_co", 32'(co), 1); chk("os_busy_run", 32'(busy), 1);
      step();
      chk("os_hold", 32'(q), 3); chk("os_done", 32'(done), 1); chk("os_busy_off", 32'(busy), 0);
      step(); chk("os_done_pulse", 32'(done), 0);
      start = 1; step(); start = 0;
      chk("os_refire_co", 32'(co), 1);
      step(); chk("os_refire_done", 32'(done), 1);
      clr = 1; step(); clr = 0;
      start = 1; step(); start = 0;
      chk("os_restart_q", 32'(q), 0);
      repeat (3) step(); chk("os_restart_q3", 32'(q), 3);
      step(); chk("os_restart_done", 32'(done), 1);
      // ld priority over a tick, clamp to max
      mode = 0; max = 10; clr = 1; step(); clr = 0;
      start = 1; step(); start = 0;
      repeat (5) step(); chk("ld_pre_q", 32'(q), 5);
      ld = 1; ld_val = 200; step(); chk("ld_clamp", 32'(q), 10);
      ld_val = 7; step(); chk("ld_val", 32'(q), 7);
      ld = 0; step(); chk("ld_resume", 32'(q), 8);
      // lowering max below q forces a wrap on the next tick
      max = 5; #1; chk("max_co", 32'(co), 1);
      step(); chk("max_wrap", 32'(q), 0);
      // cascade: lower.co drives upper.ce
      c_start = 1; step(); c_start = 0;
      repeat (99) step();
      chk("cas_lo_99", 32'(c0_q), 9); chk("cas_hi_99", 32'(c1_q), 9);
      chk("cas_hi_co", 32'(c1_co), 1);
      step();
      chk("cas_lo_100", 32'(c0_q), 0); chk("cas_hi_100", 32'(c1_q), 0);
      chk("cas_hi_co_off", 32'(c1_co), 0);
      repeat (37) step();
      chk("cas_lo_137", 32'(c0_q), 7); chk("cas_hi_137", 32'(c1_q), 3);
      c_rst = 1; rst = 1; step(); c_rst = 0; rst = 0;
      chk("cas_rst_lo", 32'(c0_q), 0); chk("cas_rst_hi", 32'(c1_q), 0);
      chk("cas_rst_busy", 32'(c0_busy | c1_busy), 0);
      chk("cas_rst_done", 32'(c0_done | c1_done), 0);
      chk("mid_rst_q", 32'(q), 3); chk("mid_rst_busy", 32'(busy), 0);
      repeat (3) step();
      chk("post_rst_q", 32'(q), 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
